// File: rtl/fp_pkg.sv
// Shared FP compare scheduler types and constants.
// State encoding, default format widths, index-width helper.
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int PRECISION     = 32;
    localparam int EXP_SIZE      = 8;
    localparam int MANTISSA_SIZE = 23;

    // Width of an index into n items (at least one bit).
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: first set req bit at or after ptr.
// Purely combinational; the pointer lives in the caller.
module rr_arbiter
    import fp_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]          req,
    input  logic [idx_w(NUM_REQ)-1:0]   ptr,
    output logic                        grant_valid,
    output logic [idx_w(NUM_REQ)-1:0]   grant_id
);

    localparam int IW = idx_w(NUM_REQ);

    int idx;

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_id    = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/fp_cmp_scheduler.sv
// Round-robin scheduler sharing one FP compare unit.
// Grant, clear the unit, wait for done (with timeout), respond.
module fp_cmp_scheduler
    import fp_pkg::*;
#(
    parameter int precision = PRECISION,
    parameter int NUM_REQ   = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*precision-1:0]  req_a,
    input  logic [NUM_REQ*precision-1:0]  req_b,
    output logic                          rsp_valid,
    output logic [idx_w(NUM_REQ)-1:0]     rsp_id,
    output logic                          rsp_res,
    output logic                          rsp_nan,
    output logic                          rsp_err,
    output logic                          busy,
    output logic                          cmp_rst_n,
    output logic [precision-1:0]          cmp_a,
    output logic [precision-1:0]          cmp_b,
    input  logic                          cmp_res,
    input  logic                          cmp_nan,
    input  logic                          cmp_done
);

    localparam int IW = idx_w(NUM_REQ);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_CLEAR = CLEAR;
    localparam logic [1:0] S_WAIT  = WAIT;
    localparam logic [1:0] S_RESP  = RESP;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    logic [1:0]           state;
    logic [1:0]           state_n;
    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        g_id;
    logic [precision-1:0] a_q;
    logic [precision-1:0] b_q;
    logic [7:0]           timer;
    logic                 gv;
    logic [IW-1:0]        gid_c;
    logic                 rst_n_q;
    logic [IW-1:0]        id_q;
    logic                 res_q;
    logic                 nan_q;
    logic                 err_q;
    logic                 tmo_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req         (req),
        .ptr         (rr_ptr),
        .grant_valid (gv),
        .grant_id    (gid_c)
    );

    assign tmo_hit = (timer == TMO);

    // Next-state selection; done takes priority over timeout.
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (gv) state_n = S_CLEAR;
            S_CLEAR: state_n = S_WAIT;
            S_WAIT:  if (cmp_done || tmo_hit) state_n = S_RESP;
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State register and registered compare-unit reset (low only in CLEAR).
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            rst_n_q <= 1'b0;
        end else begin
            state   <= state_n;
            rst_n_q <= (state_n != S_CLEAR);
        end
    end

    // Capture grant id and operands on the grant cycle only.
    always_ff @(posedge clk) begin
        if (reset) begin
            g_id <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (state == S_IDLE && gv) begin
            g_id <= gid_c;
            a_q  <= req_a[gid_c*precision +: precision];
            b_q  <= req_b[gid_c*precision +: precision];
        end
    end

    // Wait timer: cleared in CLEAR, saturating count in WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
        end else if (state == S_CLEAR) begin
            timer <= '0;
        end else if (state == S_WAIT && timer != 8'hFF) begin
            timer <= timer + 8'd1;
        end
    end

    // Response fields, loaded when leaving WAIT and held until next RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            id_q  <= '0;
            res_q <= 1'b0;
            nan_q <= 1'b0;
            err_q <= 1'b0;
        end else if (state == S_WAIT) begin
            if (cmp_done) begin
                id_q  <= g_id;
                res_q <= cmp_res;
                nan_q <= cmp_nan;
                err_q <= 1'b0;
            end else if (tmo_hit) begin
                id_q  <= g_id;
                res_q <= 1'b0;
                nan_q <= 1'b0;
                err_q <= 1'b1;
            end
        end
    end

    // Round-robin pointer moves past the requester just answered.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (state == S_RESP) begin
            if (g_id == IW'(NUM_REQ - 1)) rr_ptr <= '0;
            else                          rr_ptr <= g_id + 1'b1;
        end
    end

    assign rsp_valid = (state == S_RESP);
    assign rsp_id    = id_q;
    assign rsp_res   = res_q;
    assign rsp_nan   = nan_q;
    assign rsp_err   = err_q;
    assign busy      = (state != S_IDLE);
    assign cmp_rst_n = rst_n_q;
    assign cmp_a     = a_q;
    assign cmp_b     = b_q;

endmodule

// File: tb/tb_fp_cmp_scheduler.sv
// Directed self-checking bench for fp_cmp_scheduler.
// Includes a behavioural single-cycle compare unit with sticky done.
module tb_fp_cmp_scheduler;

    localparam int P = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*P-1:0] req_a;
    logic [N*P-1:0] req_b;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic           rsp_res;
    logic           rsp_nan;
    logic           rsp_err;
    logic           busy;
    logic           cmp_rst_n;
    logic [P-1:0]   cmp_a;
    logic [P-1:0]   cmp_b;
    logic           cmp_res;
    logic           cmp_nan;
    logic           cmp_done;
    logic           kill_done;

    int tests = 0;
    int fails = 0;

    fp_cmp_scheduler #(
        .precision (P),
        .NUM_REQ   (N),
        .TIMEOUT   (15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_res   (rsp_res),
        .rsp_nan   (rsp_nan),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .cmp_rst_n (cmp_rst_n),
        .cmp_a     (cmp_a),
        .cmp_b     (cmp_b),
        .cmp_res   (cmp_res),
        .cmp_nan   (cmp_nan),
        .cmp_done  (cmp_done)
    );

    always #5 clk = ~clk;

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction

    // Compare unit model: done one cycle after reset release, sticky.
    always_ff @(posedge clk) begin
        if (!cmp_rst_n || kill_done) begin
            cmp_done <= 1'b0;
            cmp_res  <= 1'b0;
            cmp_nan  <= 1'b0;
        end else begin
            cmp_done <= 1'b1;
            cmp_nan  <= is_nan(cmp_a) || is_nan(cmp_b);
            cmp_res  <= !(is_nan(cmp_a) || is_nan(cmp_b)) && (cmp_a == cmp_b);
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_ops(input int i, input logic [31:0] a,
                           input logic [31:0] b);
        req_a[i*P +: P] = a;
        req_b[i*P +: P] = b;
    endtask

    task automatic wait_rsp(input int maxc, output int lat, output bit got);
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= maxc && !got; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                lat = c;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = '0;
        repeat (2) @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid got %b want 0", rsp_valid);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        tests++;
        if (cmp_rst_n !== 1'b0) begin
            fails++;
            $display("FAIL reset_cmp_rst_n got %b want 0", cmp_rst_n);
        end
        tests++;
        if ({rsp_id, rsp_res, rsp_nan, rsp_err} !== 5'b0) begin
            fails++;
            $display("FAIL reset_fields got %b want 00000",
                     {rsp_id, rsp_res, rsp_nan, rsp_err});
        end
        tests++;
        if ({cmp_a, cmp_b} !== 64'h0) begin
            fails++;
            $display("FAIL reset_ops got %h want 0", {cmp_a, cmp_b});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int lat;
        int lows;
        lat  = 0;
        lows = 0;
        set_ops(0, 32'h3F800000, 32'h3F800000);
        req = 4'b0001;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (cmp_rst_n === 1'b0) lows++;
            if (rsp_valid === 1'b1 && lat == 0) begin
                lat = c;
                req = '0;
                tests++;
                if ({rsp_id, rsp_res, rsp_nan, rsp_err} !== 5'b00100) begin
                    fails++;
                    $display("FAIL single_fields got %b want 00100",
                             {rsp_id, rsp_res, rsp_nan, rsp_err});
                end
            end
        end
        req = '0;
        tests++;
        if (lat != 4) begin
            fails++;
            $display("FAIL single_latency got %0d want 4", lat);
        end
        tests++;
        if (lows != 1) begin
            fails++;
            $display("FAIL single_clear_len got %0d want 1", lows);
        end
    endtask

    task automatic test_round_robin();
        int ids[5];
        int at[5];
        int n;
        bit resv[5];
        n = 0;
        do_reset();
        for (int i = 0; i < N; i++)
            set_ops(i, 32'h3F800000, (i % 2 == 0) ? 32'h3F800000 : 32'h40000000);
        req = 4'b1111;
        for (int c = 1; c <= 40 && n < 5; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                ids[n]  = int'(rsp_id);
                at[n]   = c;
                resv[n] = rsp_res;
                n++;
                if (n == 5) req = '0;
            end
        end
        req = '0;
        tests++;
        if (n != 5) begin
            fails++;
            $display("FAIL rr_count got %0d want 5", n);
        end else begin
            for (int k = 0; k < 5; k++) begin
                tests++;
                if (ids[k] != k % 4) begin
                    fails++;
                    $display("FAIL rr_id[%0d] got %0d want %0d", k, ids[k], k % 4);
                end
                tests++;
                if (resv[k] !== ((k % 2) == 0)) begin
                    fails++;
                    $display("FAIL rr_res[%0d] got %b want %b", k, resv[k],
                             (k % 2) == 0);
                end
                if (k > 0) begin
                    tests++;
                    if (at[k] - at[k-1] != 5) begin
                        fails++;
                        $display("FAIL rr_gap[%0d] got %0d want 5", k,
                                 at[k] - at[k-1]);
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_wrap_skip();
        int lat;
        bit got;
        do_reset();
        set_ops(0, 32'h1, 32'h1);
        set_ops(2, 32'h2, 32'h2);
        req = 4'b0100;
        wait_rsp(20, lat, got);
        req = '0;
        tests++;
        if (!got || rsp_id !== 2'd2) begin
            fails++;
            $display("FAIL wrap_setup got %0d/%b want 2/1", rsp_id, got);
        end
        @(negedge clk);
        req = 4'b0101;
        wait_rsp(20, lat, got);
        req = 4'b0100;
        tests++;
        if (!got || rsp_id !== 2'd0) begin
            fails++;
            $display("FAIL wrap_first got %0d/%b want 0/1", rsp_id, got);
        end
        wait_rsp(20, lat, got);
        req = '0;
        tests++;
        if (!got || rsp_id !== 2'd2) begin
            fails++;
            $display("FAIL wrap_second got %0d/%b want 2/1", rsp_id, got);
        end
        @(negedge clk);
    endtask

    task automatic test_nan();
        int lat;
        bit got;
        set_ops(1, 32'h7FA00000, 32'h3F800000);
        req = 4'b0010;
        wait_rsp(20, lat, got);
        req = '0;
        tests++;
        if (!got || {rsp_id, rsp_res, rsp_nan, rsp_err} !== 5'b01010) begin
            fails++;
            $display("FAIL nan_fields got %b/%b want 01010/1",
                     {rsp_id, rsp_res, rsp_nan, rsp_err}, got);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int lat;
        bit got;
        kill_done = 1'b1;
        set_ops(3, 32'h3F800000, 32'h3F800000);
        req = 4'b1000;
        wait_rsp(40, lat, got);
        req = '0;
        tests++;
        if (!got || lat != 18) begin
            fails++;
            $display("FAIL tmo_latency got %0d/%b want 18/1", lat, got);
        end
        tests++;
        if ({rsp_id, rsp_res, rsp_nan, rsp_err} !== 5'b11001) begin
            fails++;
            $display("FAIL tmo_fields got %b want 11001",
                     {rsp_id, rsp_res, rsp_nan, rsp_err});
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL tmo_idle_busy got %b want 0", busy);
        end
        kill_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        set_ops(0, 32'h3F800000, 32'h3F800000);
        req = 4'b0001;
        repeat (3) @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_busy_before got %b want 1", busy);
        end
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        tests++;
        if ({rsp_valid, busy, cmp_rst_n} !== 3'b000) begin
            fails++;
            $display("FAIL mid_ctrl got %b want 000", {rsp_valid, busy, cmp_rst_n});
        end
        tests++;
        if ({rsp_id, rsp_res, rsp_nan, rsp_err, cmp_a} !== 37'h0) begin
            fails++;
            $display("FAIL mid_fields got %h want 0",
                     {rsp_id, rsp_res, rsp_nan, rsp_err, cmp_a});
        end
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL mid_no_rsp got %0d want 0", seen);
        end
    endtask

    task automatic test_operand_hold();
        int lat;
        bit got;
        int bad;
        bad = 0;
        set_ops(0, 32'h3F800000, 32'h3F800000);
        req = 4'b0001;
        @(negedge clk);
        req_a[0 +: P] = 32'h12345678;
        for (int c = 0; c < 2; c++) begin
            if (cmp_a !== 32'h3F800000) bad++;
            @(negedge clk);
        end
        tests++;
        if (bad != 0 || cmp_a !== 32'h3F800000) begin
            fails++;
            $display("FAIL hold_cmp_a got %h want 3f800000", cmp_a);
        end
        wait_rsp(20, lat, got);
        req = '0;
        tests++;
        if (!got || rsp_res !== 1'b1 || rsp_nan !== 1'b0) begin
            fails++;
            $display("FAIL hold_result got %b%b/%b want 10/1", rsp_res, rsp_nan, got);
        end
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        req       = '0;
        req_a     = '0;
        req_b     = '0;
        kill_done = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_wrap_skip();
        test_nan();
        test_timeout();
        test_reset_mid();
        test_operand_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_cmp_scheduler.md
Name: fp_cmp_scheduler

Overview:
- Shares one single-cycle floating-point compare unit (the FPU equality block) between NUM_REQ requesters using round-robin arbitration.
- Each granted request follows the same sequence:
  - latch the requester's operands;
  - pulse the compare unit's active-low reset to clear its sticky done flag;
  - wait for done, with a timeout;
  - return the result and NaN flag to the requester.
- Sits between the FPU request fabric and the compare datapath.

Parameters:
- precision, 32, operand width in bits.
- NUM_REQ, 4, number of requesters (2..16).
- TIMEOUT, 15, max cycles waited for cmp_done before erroring (1..255).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request level.
- req_a  input  NUM_REQ*precision  operand A per requester; slice i = bits [i*precision +: precision].
- req_b  input  NUM_REQ*precision  operand B per requester, same packing as req_a.
- rsp_valid  output  1  one-cycle pulse; response fields are valid this cycle.
- rsp_id  output  $clog2(NUM_REQ)  index of the requester being answered.
- rsp_res  output  1  compare result.
- rsp_nan  output  1  NaN exception from the compare unit.
- rsp_err  output  1  timeout; rsp_res = 0 and rsp_nan = 0 when set.
- busy  output  1  high in any state other than IDLE.
- cmp_rst_n  output  1  active-low reset to the compare unit.
- cmp_a  output  precision  operand A to the compare unit.
- cmp_b  output  precision  operand B to the compare unit.
- cmp_res  input  1  compare unit result.
- cmp_nan  input  1  compare unit nan_exception.
- cmp_done  input  1  compare unit done; sticky until the unit is reset.

Behaviour:
- Reset (reset = 1, sampled at clk):
  - state = IDLE; rr_ptr = 0.
  - rsp_valid, rsp_res, rsp_nan, rsp_err = 0; rsp_id = 0; busy = 0.
  - cmp_rst_n = 0, which holds the compare unit in reset; cmp_a = cmp_b = 0.
  - Reset asserted mid-operation aborts it: no rsp_valid is produced and the requester must re-request.
- IDLE:
  - cmp_rst_n = 1.
  - If req != 0, grant the first set bit searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - Latch g_id, req_a slice and req_b slice into internal registers, then go to CLEAR.
  - Operand changes after the grant cycle are ignored.
- CLEAR (1 cycle):
  - cmp_rst_n = 0; cmp_a/cmp_b driven from the latched operands; timer cleared to 0; then go to WAIT.
- WAIT:
  - cmp_rst_n = 1; operands held stable; timer increments each cycle.
  - If cmp_done = 1: capture cmp_res and cmp_nan, rsp_err = 0, go to RESP.
  - Else if timer == TIMEOUT: rsp_res = 0, rsp_nan = 0, rsp_err = 1, go to RESP.
  - If cmp_done is seen on the same cycle the timer reaches TIMEOUT, done wins.
  - The timer saturates and never wraps.
  - Nominal path: cmp_done is seen on the 2nd WAIT cycle.
- RESP (1 cycle):
  - rsp_valid = 1; rsp_id = g_id; rsp_res, rsp_nan, rsp_err hold their registered values.
  - rr_ptr = (g_id + 1) mod NUM_REQ; go to IDLE.
- Latency from req rising in IDLE to the rsp_valid cycle is 4 cycles nominal: grant, CLEAR, WAIT x2, RESP at cycle 5. Minimum request-to-request spacing is 5 cycles.
- Requester rule: drop req in the cycle after its rsp_valid. If req is still high, it counts as a new request and is served after the other pending requesters (the pointer has moved past it).
- req deasserting while its request is in flight has no effect; the request completes.
- Response fields other than rsp_valid retain their values until the next RESP cycle.
- busy = (state != IDLE).
- Only one operation is ever outstanding.

Decomposition:
- Shared package fp_pkg:
  - state enum {IDLE, CLEAR, WAIT, RESP};
  - default precision / exp_size / mantissa_size constants;
  - a clog2-based index-width helper.
- One natural sub-module: rr_arbiter.
  - Parameter NUM_REQ.
  - Inputs: req and ptr. Outputs: grant_valid and grant_id.
  - Purely combinational rotate-priority search.
- Timer and FSM stay in the top-level module.

Test Plan:
- Single request, equal operands: req = 4'b0001, a = b = 0x3F800000, with a model of the compare unit attached → cmp_rst_n low for exactly 1 cycle; rsp_valid at cycle 5 with rsp_id = 0, rsp_res = 1, rsp_nan = 0, rsp_err = 0.
- Round-robin fairness: req = 4'b1111 held continuously → rsp_id sequence 0, 1, 2, 3, 0, with rsp_valid every 5 cycles.
- Pointer wrap and skip: rr_ptr = 3 and req = 4'b0101 → next grant is id 0, then id 2.
- NaN and unequal operands: a = 0x7FA00000, b = 0x3F800000 → rsp_nan = 1, rsp_res = 0.
- Timeout: cmp_done tied to 0, TIMEOUT = 15 → rsp_valid with rsp_err = 1, rsp_res = 0, 18 cycles after the grant; FSM returns to IDLE and busy = 0.
- Reset mid-operation and operand stability: assert reset during WAIT → no rsp_valid, all outputs at reset values, cmp_rst_n = 0. Separately, change req_a after the grant → cmp_a still shows the latched value.
